// File: rtl/imm_pkg.sv
// Shared opcodes, format encoding and pipeline beat type for the immediate generator.
package imm_pkg;

  localparam int unsigned MaxXlen = 64;

  localparam logic [6:0] OpLoad    = 7'b0000011;
  localparam logic [6:0] OpOpImm   = 7'b0010011;
  localparam logic [6:0] OpAuipc   = 7'b0010111;
  localparam logic [6:0] OpOpImm32 = 7'b0011011;
  localparam logic [6:0] OpStore   = 7'b0100011;
  localparam logic [6:0] OpOp      = 7'b0110011;
  localparam logic [6:0] OpLui     = 7'b0110111;
  localparam logic [6:0] OpOp32    = 7'b0111011;
  localparam logic [6:0] OpBranch  = 7'b1100011;
  localparam logic [6:0] OpJalr    = 7'b1100111;
  localparam logic [6:0] OpJal     = 7'b1101111;
  localparam logic [6:0] OpSystem  = 7'b1110011;

  typedef enum logic [2:0] {
    FmtR     = 3'd0,
    FmtI     = 3'd1,
    FmtS     = 3'd2,
    FmtB     = 3'd3,
    FmtU     = 3'd4,
    FmtJ     = 3'd5,
    FmtShamt = 3'd6,
    FmtNone  = 3'd7
  } fmt_e;

  // pc/imm are sized for the widest XLEN; narrower builds use the low bits only.
  typedef struct packed {
    logic [31:0]        instr;
    logic [MaxXlen-1:0] pc;
    logic [MaxXlen-1:0] imm;
    fmt_e               fmt;
    logic               illegal;
  } beat_t;

  function automatic bit xlen_legal(input int unsigned xlen);
    return (xlen == 32) || (xlen == 64);
  endfunction

  function automatic logic [MaxXlen-1:0] sext32(input logic [31:0] val);
    return {{(MaxXlen-32){val[31]}}, val};
  endfunction

  function automatic beat_t beat_reset();
    beat_t b;
    b.instr   = '0;
    b.pc      = '0;
    b.imm     = '0;
    b.fmt     = FmtNone;
    b.illegal = 1'b0;
    return b;
  endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I/RV64I immediate decoder: instruction word to {imm, fmt, illegal}.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:0]     instr,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  localparam bit Rv64 = (XLEN == 64);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $fatal(1, "imm_decode: XLEN must be 32 or 64");
  end

  logic [6:0]         opcode;
  logic [2:0]         funct3;
  logic               is_shift;
  logic [31:0]        imm_w;
  logic [MaxXlen-1:0] imm_full;
  fmt_e               fmt_d;

  assign opcode   = instr[6:0];
  assign funct3   = instr[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

  // Every format fits in 32 bits sign-extended; widening to XLEN happens once below.
  always_comb begin
    imm_w   = '0;
    fmt_d   = FmtNone;
    illegal = 1'b0;
    case (opcode)
      OpOpImm: begin
        if (is_shift) begin
          fmt_d = FmtShamt;
          imm_w = Rv64 ? {26'b0, instr[25:20]} : {27'b0, instr[24:20]};
        end else begin
          fmt_d = FmtI;
          imm_w = 32'($signed(instr[31:20]));
        end
      end
      OpOpImm32: begin
        if (!Rv64) begin
          illegal = 1'b1;
        end else if (is_shift) begin
          fmt_d = FmtShamt;
          imm_w = {27'b0, instr[24:20]};
        end else begin
          fmt_d = FmtI;
          imm_w = 32'($signed(instr[31:20]));
        end
      end
      OpLoad, OpJalr, OpSystem: begin
        fmt_d = FmtI;
        imm_w = 32'($signed(instr[31:20]));
      end
      OpStore: begin
        fmt_d = FmtS;
        imm_w = 32'($signed({instr[31:25], instr[11:7]}));
      end
      OpBranch: begin
        fmt_d = FmtB;
        imm_w = 32'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
      end
      OpLui, OpAuipc: begin
        fmt_d = FmtU;
        imm_w = {instr[31:12], 12'b0};
      end
      OpJal: begin
        fmt_d = FmtJ;
        imm_w = 32'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
      end
      OpOp: begin
        fmt_d = FmtR;
      end
      OpOp32: begin
        if (Rv64) begin
          fmt_d = FmtR;
        end else begin
          illegal = 1'b1;
        end
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

  assign imm_full = sext32(imm_w);
  assign imm      = imm_full[XLEN-1:0];
  assign fmt      = fmt_d;

  logic unused_imm_hi;
  assign unused_imm_hi = ^imm_full;

endmodule

// File: rtl/imm_gen_stage.sv
// Decode-stage immediate generator: imm_decode behind a valid/ready output register
// with an optional one-entry skid buffer and synchronous flush.
module imm_gen_stage
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SKID = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc
);

  if (!xlen_legal(XLEN)) begin : g_bad_xlen
    $fatal(1, "imm_gen_stage: XLEN must be 32 or 64");
  end
  if (SKID > 1) begin : g_bad_skid
    $fatal(1, "imm_gen_stage: SKID must be 0 or 1");
  end

  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_fmt;
  logic            dec_illegal;

  imm_decode #(
    .XLEN(XLEN)
  ) u_decode (
    .instr  (in_instr),
    .imm    (dec_imm),
    .fmt    (dec_fmt),
    .illegal(dec_illegal)
  );

  beat_t in_beat;
  beat_t out_q, out_d;
  beat_t skid_q, skid_d;
  logic  out_valid_q, out_valid_d;
  logic  skid_valid_q, skid_valid_d;
  logic  accept;
  logic  out_free;

  always_comb begin
    in_beat.instr   = in_instr;
    in_beat.pc      = MaxXlen'(in_pc);
    in_beat.imm     = MaxXlen'(dec_imm);
    in_beat.fmt     = fmt_e'(dec_fmt);
    in_beat.illegal = dec_illegal;
  end

  // With a skid entry, in_ready depends only on state so no out_ready->in_ready path exists.
  assign in_ready = (SKID != 0) ? !skid_valid_q : (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready && !flush;
  assign out_free = !out_valid_q || out_ready;

  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (out_free) begin
      // accept is impossible while the skid is occupied, so the skid drains first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept && (SKID != 0)) begin
      skid_d       = in_beat;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= beat_reset();
      out_valid_q  <= 1'b0;
      skid_q       <= beat_reset();
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_fmt     = out_q.fmt;
  assign out_illegal = out_q.illegal;
  assign out_instr   = out_q.instr;
  assign out_pc      = out_q.pc[XLEN-1:0];

  logic unused_beat_hi;
  assign unused_beat_hi = ^{out_q.pc, out_q.imm};

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Parametrised, pipelined successor to the combinational immediate generator. It sits in the decode stage between the fetch buffer and the register-read/execute stage. It decodes the immediate of every RV32I/RV64I format with full sign extension to XLEN and classifies the format. It carries instr/pc alongside, using a valid/ready handshake with a 1-entry skid buffer and a synchronous flush.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64; any other value is a fatal elaboration error.
SKID, 1, 1 = output register plus skid entry (full throughput); 0 = output register only (in_ready = !out_valid || out_ready).

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous; drops all held beats and any beat offered this cycle
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_instr  in  32  raw instruction word
in_pc  in  XLEN  instruction address
out_valid  out  1  decoded beat valid
out_ready  in  1  downstream accepts the beat
out_imm  out  XLEN  sign/zero-extended immediate
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 6=SHAMT 7=NONE
out_illegal  out  1  opcode not recognised for this XLEN
out_instr  out  32  registered copy of in_instr
out_pc  out  XLEN  registered copy of in_pc

Behaviour:
- Reset (async, rst=1): out_valid=0, skid_valid=0, out_imm=0, out_fmt=7, out_illegal=0, out_instr=0, out_pc=0. in_ready=1 once skid is empty.
- Decode by opcode in_instr[6:0]:
  - I: OP_IMM 0010011, LOAD 0000011, JALR 1100111, SYSTEM 1110011. imm = sext(instr[31:20]).
  - S: 0100011. imm = sext({instr[31:25], instr[11:7]}).
  - B: 1100011. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - U: LUI 0110111, AUIPC 0010111. imm = sext({instr[31:12], 12'b0}). For XLEN=64, bit 31 is replicated into [63:32].
  - J: 1101111. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R: 0110011. imm = 0.
  - XLEN=64 only: OP_IMM_32 0011011 decodes as I, OP_32 0111011 decodes as R. At XLEN=32 these are illegal.
  - SHAMT: OP_IMM with funct3 001 or 101. imm = zero-extended instr[24:20] (XLEN=32) or instr[25:20] (XLEN=64). Funct7/funct6 bits are excluded. OP_IMM_32 shifts always use the 5-bit shamt.
  - Any other opcode: fmt=NONE, imm=0, out_illegal=1. The beat still flows; it is never dropped.
- Handshake:
  - Accept when in_valid && in_ready && !flush.
  - Latency: an accepted beat appears on out_* the next cycle when the output register is empty or draining.
  - out_* hold stable while out_valid && !out_ready.
- SKID=1:
  - in_ready = !skid_valid, taken from a register and not combinational on out_ready.
  - A beat accepted while the output is stalled goes to the skid entry.
  - When out_ready returns, the skid entry moves to the output register in the same cycle the old beat retires.
  - Order is strictly preserved. Sustains 1 beat/cycle with no bubbles.
- Flush: at the next edge, out_valid=0 and skid_valid=0. A beat offered in the flush cycle is discarded. Flush has priority over accept and over out_ready.
- Simultaneous retire (out_valid && out_ready) and accept with an empty skid: the new beat loads directly into the output register and out_valid stays 1.
- Reset mid-stream: all held beats are lost immediately. No partial outputs.

Decomposition:
- Package imm_pkg holds: opcode localparams, the fmt_e enum (R, I, S, B, U, J, SHAMT, NONE, 3 bits), and the beat struct {instr, pc, imm, fmt, illegal}, parametrised via XLEN localparam functions.
- Sub-module imm_decode: purely combinational instr-to-{imm, fmt, illegal}, parameter XLEN. It is reusable by the branch predictor.
- imm_gen_stage contains imm_decode, the output register, the skid entry and the handshake logic.

Test Plan:
- XLEN=32: addi 0xFFF00093 -> imm 0xFFFFFFFF, fmt I. sw 0xFE20AE23 -> imm 0xFFFFFFFC, fmt S. beq 0xFE000CE3 -> imm 0xFFFFFFF8, fmt B. Each appears 1 cycle after accept.
- XLEN=64: lui 0x800002B7 -> imm 0xFFFFFFFF80000000, fmt U. slli 0x03F09093 -> imm 0x3F, fmt SHAMT. srai 0x43F0D093 -> imm 0x3F, not 0x43F.
- Illegal and width-dependent opcodes: 0x0000007F -> illegal=1, fmt NONE, imm 0. addiw 0x0010009B at XLEN=32 -> illegal=1; at XLEN=64 -> fmt I, imm 1.
- Backpressure: hold out_ready=0 and offer 3 beats A, B, C back-to-back -> A and B accepted, in_ready=0 on the third cycle, C held upstream. Releasing out_ready yields A, B, C in order with no bubble, and out_* stay stable during the stall.
- Flush with full skid and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered beat is not seen at the output.
- Assert rst mid-stall with 2 beats held -> out_valid=0 immediately (asynchronously) and all outputs at their reset values. After release, a new beat appears with 1-cycle latency.
